// File: rtl/fp16_seg_display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_disp_pkg
// Brief    : Segment constants, class encoding and classifier for the FP16 display
// Revision : 1.0  initial release
// ============================================================================
package fp16_disp_pkg;

    // Segment patterns are active-low, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_I     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,   // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,   // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,   // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        CLS_NUM  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    function automatic cls_t classify(input logic [4:0] exp_f, input logic [9:0] frac_f);
        cls_t c;
        c = CLS_NUM;
        if (exp_f == 5'h1F) begin
            c = (frac_f != 10'd0) ? CLS_NAN : CLS_INF;
        end else if (exp_f == 5'h00 && frac_f == 10'd0) begin
            c = CLS_ZERO;
        end
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp16_seg_display_if.sv
`default_nettype none
// ============================================================================
// Module   : fp16_seg_display_if
// Brief    : Value/mode input and multiplexed 7-segment output bundle
// Revision : 1.0  initial release
// ============================================================================
interface fp16_seg_display_if;
    logic [15:0] value;
    logic        sym_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    modport master (output value, sym_en, input an, seg, dp, frame_start);
    modport slave  (input value, sym_en, output an, seg, dp, frame_start);
endinterface
`default_nettype wire

// File: rtl/fp16_seg_display_hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_seg
// Brief    : Combinational 4-bit nibble to active-low 7-segment decoder
// Revision : 1.0  initial release
// ============================================================================
module hex_to_seg
    import fp16_disp_pkg::*;
(
    input  wire logic [3:0] nibble,
    output logic      [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule
`default_nettype wire

// File: rtl/fp16_seg_display.sv
`default_nettype none
// ============================================================================
// Module   : fp16_seg_display
// Brief    : Frame-latched 4-digit multiplexed 7-segment display of an FP16 word
// Revision : 1.0  initial release
// ============================================================================
module fp16_seg_display
    import fp16_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fp16_seg_display_if.slave  bus
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic [15:0]      r_shadow_val;
    logic             r_shadow_sym;
    logic             r_tick_d;
    logic [3:0]       r_an;
    logic [6:0]       r_seg;
    logic             r_dp;
    logic             r_frame_start;

    logic             w_tick;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex_seg;
    logic [6:0]       w_sym_seg;
    cls_t             w_cls;
    logic             w_hex_mode;

    assign w_tick = (r_div == c_div_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div        <= '0;
            r_idx        <= 2'd3;
            r_shadow_val <= '0;
            r_shadow_sym <= 1'b0;
            r_tick_d     <= 1'b0;
        end else begin
            r_tick_d <= w_tick;
            if (w_tick) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
                // Latch only at frame boundaries so one frame never mixes two words
                if (r_idx == 2'd3) begin
                    r_shadow_val <= bus.value;
                    r_shadow_sym <= bus.sym_en;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

    always_comb begin
        w_nibble = r_shadow_val[3:0];
        case (r_idx)
            2'd1:    w_nibble = r_shadow_val[7:4];
            2'd2:    w_nibble = r_shadow_val[11:8];
            2'd3:    w_nibble = r_shadow_val[15:12];
            default: w_nibble = r_shadow_val[3:0];
        endcase
    end

    hex_to_seg u_hex_to_seg (
        .nibble (w_nibble),
        .seg    (w_hex_seg)
    );

    assign w_cls      = classify(r_shadow_val[14:10], r_shadow_val[9:0]);
    assign w_hex_mode = !r_shadow_sym || (w_cls == CLS_NUM);

    always_comb begin
        w_sym_seg = SEG_BLANK;
        case (w_cls)
            CLS_NAN: begin
                case (r_idx)
                    2'd3:    w_sym_seg = SEG_N;
                    2'd2:    w_sym_seg = SEG_A;
                    2'd1:    w_sym_seg = SEG_N;
                    default: w_sym_seg = SEG_BLANK;
                endcase
            end
            CLS_INF: begin
                case (r_idx)
                    2'd3:    w_sym_seg = r_shadow_val[15] ? SEG_DASH : SEG_BLANK;
                    2'd2:    w_sym_seg = SEG_I;
                    2'd1:    w_sym_seg = SEG_N;
                    default: w_sym_seg = SEG_F;
                endcase
            end
            CLS_ZERO: w_sym_seg = (r_idx == 2'd0) ? SEG_HEX[0] : SEG_BLANK;
            default:  w_sym_seg = SEG_BLANK;
        endcase
    end

    // Outputs refresh one cycle after each tick; before the first tick they stay blank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an          <= 4'b1111;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= r_tick_d && (r_idx == 2'd0);
            if (r_tick_d) begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= w_hex_mode ? w_hex_seg : w_sym_seg;
                r_dp  <= !(w_hex_mode && (r_idx == 2'd3) && r_shadow_val[15]);
            end
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.dp          = r_dp;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire
